// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler: MAIN rest phase, gap-extended MT and S
// phases, yellow/all-red clearance and emergency preemption with a HOLD state.
module traffic_phase_scheduler #(
  parameter int T_MIN_GREEN = 8,
  parameter int T_MAX_GREEN = 16,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_s,
  input  logic       req_mt,
  input  logic       emerg,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [1:0] phase,
  output logic       emerg_ack
);

  typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, HOLD} state_t;

  localparam logic [1:0] PH_MAIN = 2'd0;
  localparam logic [1:0] PH_MT   = 2'd1;
  localparam logic [1:0] PH_S    = 2'd2;
  localparam logic [2:0] LAMP_R  = 3'b100;
  localparam logic [2:0] LAMP_Y  = 3'b010;
  localparam logic [2:0] LAMP_G  = 3'b001;
  localparam logic [7:0] MIN_LAST = 8'(T_MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST = 8'(T_MAX_GREEN - 1);
  localparam logic [7:0] YEL_LAST = 8'(T_YELLOW - 1);
  localparam logic [7:0] AR_LAST  = 8'(T_ALLRED - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] next_phase_q, next_phase_d;
  logic       pend_s_q, pend_s_d;
  logic       pend_mt_q, pend_mt_d;
  logic [2:0] light_m1_q, light_m1_d;
  logic [2:0] light_m2_q, light_m2_d;
  logic [2:0] light_mt_q, light_mt_d;
  logic [2:0] light_s_q, light_s_d;
  logic       emerg_ack_q, emerg_ack_d;

  logic       min_done;
  logic       own_req;
  logic       enter_green;
  logic [2:0] lamp_on;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    next_phase_d = next_phase_q;
    own_req      = (phase_q == PH_S) ? req_s : req_mt;
    min_done     = (timer_q >= MIN_LAST);

    case (state_q)
      GREEN: begin
        if (emerg) begin
          state_d      = YELLOW;
          next_phase_d = PH_MAIN;
        end else if (phase_q == PH_MAIN) begin
          if (min_done && (pend_s_q || pend_mt_q)) begin
            state_d      = YELLOW;
            next_phase_d = pend_mt_q ? PH_MT : PH_S;
          end
        end else if ((min_done && !own_req) || (timer_q >= MAX_LAST)) begin
          state_d      = YELLOW;
          next_phase_d = ((phase_q == PH_MT) && pend_s_q) ? PH_S : PH_MAIN;
        end
      end
      YELLOW: begin
        if (timer_q >= YEL_LAST) state_d = ALLRED;
      end
      ALLRED: begin
        if (timer_q >= AR_LAST) begin
          if (emerg) begin
            state_d = HOLD;
          end else begin
            state_d = GREEN;
            phase_d = next_phase_q;
          end
        end
      end
      HOLD: begin
        if (!emerg) begin
          state_d = GREEN;
          phase_d = PH_MAIN;
        end
      end
      default: state_d = ALLRED;
    endcase

    // Timer saturates so an indefinitely resting MAIN green never wraps.
    if (state_d != state_q) timer_d = 8'd0;
    else if (timer_q == 8'hFF) timer_d = timer_q;
    else timer_d = timer_q + 8'd1;

    enter_green = (state_d == GREEN) && (state_q != GREEN);
    pend_s_d  = (enter_green && (phase_d == PH_S)) ? 1'b0 :
                (pend_s_q | (req_s && !((state_q == GREEN) && (phase_q == PH_S))));
    pend_mt_d = (enter_green && (phase_d == PH_MT)) ? 1'b0 :
                (pend_mt_q | (req_mt && !((state_q == GREEN) && (phase_q == PH_MT))));

    // Lamps follow the next state so they are registered alongside it.
    light_m1_d = LAMP_R;
    light_m2_d = LAMP_R;
    light_mt_d = LAMP_R;
    light_s_d  = LAMP_R;
    lamp_on    = (state_d == GREEN) ? LAMP_G : LAMP_Y;
    if ((state_d == GREEN) || (state_d == YELLOW)) begin
      case (phase_d)
        PH_MAIN: begin
          light_m1_d = lamp_on;
          light_m2_d = lamp_on;
        end
        PH_MT: begin
          light_m1_d = lamp_on;
          light_mt_d = lamp_on;
        end
        PH_S:    light_s_d = lamp_on;
        default: light_s_d = LAMP_R;
      endcase
    end
    emerg_ack_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ALLRED;
      timer_q      <= 8'd0;
      phase_q      <= PH_MAIN;
      next_phase_q <= PH_MAIN;
      pend_s_q     <= 1'b0;
      pend_mt_q    <= 1'b0;
      light_m1_q   <= LAMP_R;
      light_m2_q   <= LAMP_R;
      light_mt_q   <= LAMP_R;
      light_s_q    <= LAMP_R;
      emerg_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
      next_phase_q <= next_phase_d;
      pend_s_q     <= pend_s_d;
      pend_mt_q    <= pend_mt_d;
      light_m1_q   <= light_m1_d;
      light_m2_q   <= light_m2_d;
      light_mt_q   <= light_mt_d;
      light_s_q    <= light_s_d;
      emerg_ack_q  <= emerg_ack_d;
    end
  end

  assign light_M1  = light_m1_q;
  assign light_M2  = light_m2_q;
  assign light_MT  = light_mt_q;
  assign light_S   = light_s_q;
  assign phase     = phase_q;
  assign emerg_ack = emerg_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector table, corner-case sequences and a
// randomized run compared every cycle against a behavioural reference model.
module tb_traffic_phase_scheduler;

  localparam int T_MIN = 8;
  localparam int T_MAX = 16;
  localparam int T_Y   = 3;
  localparam int T_AR  = 2;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  localparam logic [11:0] ALL_R  = {R, R, R, R};
  localparam logic [11:0] MAIN_G = {G, G, R, R};
  localparam logic [11:0] MAIN_Y = {Y, Y, R, R};
  localparam logic [11:0] S_G    = {R, R, R, G};
  localparam logic [11:0] S_Y    = {R, R, R, Y};

  localparam int SEG_GREEN  = 0;
  localparam int SEG_YELLOW = 1;
  localparam int SEG_ALLRED = 2;
  localparam int SEG_HOLD   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_s = 1'b0;
  logic       req_mt = 1'b0;
  logic       emerg = 1'b0;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [1:0] phase;
  logic       emerg_ack;

  int checks = 0;
  int errors = 0;

  traffic_phase_scheduler #(
    .T_MIN_GREEN(T_MIN),
    .T_MAX_GREEN(T_MAX),
    .T_YELLOW(T_Y),
    .T_ALLRED(T_AR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_s(req_s),
    .req_mt(req_mt),
    .emerg(emerg),
    .light_M1(light_M1),
    .light_M2(light_M2),
    .light_MT(light_MT),
    .light_S(light_S),
    .phase(phase),
    .emerg_ack(emerg_ack)
  );

  always #5 clk = ~clk;

  // Reference model: which segment of the signal plan is showing, for which
  // approach, how many edges it has been showing, and outstanding demand.
  int m_seg, m_phase, m_next, m_elapsed;
  bit m_ps, m_pmt;

  function automatic logic [11:0] lampsFor(input int seg, input int ph);
    logic [3:0]  mask;
    logic [2:0]  on;
    logic [11:0] r;
    case (ph)
      0:       mask = 4'b1100;
      1:       mask = 4'b1010;
      default: mask = 4'b0001;
    endcase
    on = (seg == SEG_GREEN) ? G : Y;
    for (int i = 0; i < 4; i++) r[i*3 +: 3] = (mask[i] && seg <= SEG_YELLOW) ? on : R;
    return r;
  endfunction

  task automatic modelReset();
    m_seg = SEG_ALLRED; m_phase = 0; m_next = 0; m_elapsed = 0; m_ps = 0; m_pmt = 0;
  endtask

  task automatic modelStep(input bit rs, input bit rmt, input bit em);
    int  nseg, nph, nnext;
    bit  showing_s, showing_mt, own;
    nseg = m_seg; nph = m_phase; nnext = m_next;
    showing_s  = (m_seg == SEG_GREEN) && (m_phase == 2);
    showing_mt = (m_seg == SEG_GREEN) && (m_phase == 1);
    own = (m_phase == 2) ? rs : rmt;
    case (m_seg)
      SEG_GREEN: begin
        if (em) begin
          nseg = SEG_YELLOW; nnext = 0;
        end else if (m_phase == 0) begin
          if (m_elapsed >= T_MIN - 1 && (m_ps || m_pmt)) begin
            nseg = SEG_YELLOW; nnext = m_pmt ? 1 : 2;
          end
        end else if ((m_elapsed >= T_MIN - 1 && !own) || m_elapsed == T_MAX - 1) begin
          nseg = SEG_YELLOW; nnext = (m_phase == 1 && m_ps) ? 2 : 0;
        end
      end
      SEG_YELLOW: if (m_elapsed == T_Y - 1) nseg = SEG_ALLRED;
      SEG_ALLRED: if (m_elapsed == T_AR - 1) begin
        if (em) nseg = SEG_HOLD;
        else begin nseg = SEG_GREEN; nph = m_next; end
      end
      default: if (!em) begin nseg = SEG_GREEN; nph = 0; end
    endcase
    m_ps  = m_ps  | (rs  && !showing_s);
    m_pmt = m_pmt | (rmt && !showing_mt);
    if (nseg == SEG_GREEN && m_seg != SEG_GREEN) begin
      if (nph == 2) m_ps = 0;
      if (nph == 1) m_pmt = 0;
    end
    m_elapsed = (nseg != m_seg) ? 0 : m_elapsed + 1;
    m_seg = nseg; m_phase = nph; m_next = nnext;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] exp_l,
                             input logic [1:0] exp_ph, input logic exp_ack);
    logic [11:0] act;
    act = {light_M1, light_M2, light_MT, light_S};
    checks++;
    if (act !== exp_l || phase !== exp_ph || emerg_ack !== exp_ack) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got lamps=%b phase=%0d ack=%b, expected lamps=%b phase=%0d ack=%b",
               name, $time, act, phase, emerg_ack, exp_l, exp_ph, exp_ack);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock edge with the given inputs; outputs compared to the model after it.
  task automatic applyStimulus(input bit rs, input bit rmt, input bit em);
    req_s = rs; req_mt = rmt; emerg = em;
    modelStep(rs, rmt, em);
    @(posedge clk);
    #1;
    checkOutput("model", lampsFor(m_seg, m_phase), 2'(m_phase), m_seg == SEG_HOLD);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset", ALL_R, 2'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rs;
    bit          rmt;
    bit          em;
    int          n;
    logic [11:0] lamps;
    logic [1:0]  ph;
    bit          ack;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit rs, input bit rmt, input bit em, input int n,
                        input logic [11:0] lamps, input logic [1:0] ph, input bit ack);
    vec_t v;
    v.rs = rs; v.rmt = rmt; v.em = em; v.n = n; v.lamps = lamps; v.ph = ph; v.ack = ack;
    vecs.push_back(v);
  endtask

  int order[$];
  int exp_order[3] = '{1, 2, 0};
  int mt_g, s_g, yel, red, cnt;
  bit prev_green, any_g, found, em_lvl;

  initial begin
    #2;
    applyReset();

    addVec(0, 0, 0, 0,   ALL_R,  2'd0, 0);
    addVec(0, 0, 0, 1,   ALL_R,  2'd0, 0);
    addVec(0, 0, 0, 1,   MAIN_G, 2'd0, 0);
    addVec(0, 0, 0, 100, MAIN_G, 2'd0, 0);
    addVec(1, 0, 0, 1,   MAIN_G, 2'd0, 0);
    addVec(0, 0, 0, 1,   MAIN_Y, 2'd0, 0);
    addVec(0, 0, 0, 2,   MAIN_Y, 2'd0, 0);
    addVec(0, 0, 0, 1,   ALL_R,  2'd0, 0);
    addVec(0, 0, 0, 1,   ALL_R,  2'd0, 0);
    addVec(0, 0, 0, 1,   S_G,    2'd2, 0);
    addVec(0, 0, 0, 7,   S_G,    2'd2, 0);
    addVec(0, 0, 0, 1,   S_Y,    2'd2, 0);
    addVec(0, 0, 0, 2,   S_Y,    2'd2, 0);
    addVec(0, 0, 0, 1,   ALL_R,  2'd2, 0);
    addVec(0, 0, 0, 1,   ALL_R,  2'd2, 0);
    addVec(0, 0, 0, 1,   MAIN_G, 2'd0, 0);
    addVec(0, 0, 0, 30,  MAIN_G, 2'd0, 0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) applyStimulus(vecs[i].rs, vecs[i].rmt, vecs[i].em);
      checkOutput($sformatf("vec%0d", i), vecs[i].lamps, vecs[i].ph, vecs[i].ack);
    end

    // MT and S requested together: MT first, then S, then back to MAIN.
    mt_g = 0; s_g = 0; yel = 0; red = 0; prev_green = 1;
    applyStimulus(1, 1, 0);
    for (int k = 0; k < 60; k++) begin
      applyStimulus(0, 0, 0);
      any_g = (light_M1 == G) || (light_S == G);
      if (any_g && !prev_green) order.push_back(int'(phase));
      prev_green = any_g;
      if (light_MT == G) mt_g++;
      if (light_S == G) s_g++;
      if (light_M1 == Y || light_S == Y) yel++;
      if ({light_M1, light_M2, light_MT, light_S} == ALL_R) red++;
    end
    checkValue("dual_order_len", order.size(), 3);
    for (int i = 0; i < 3; i++)
      checkValue($sformatf("dual_order%0d", i), (order.size() > i) ? order[i] : -1, exp_order[i]);
    checkValue("dual_mt_green", mt_g, 8);
    checkValue("dual_s_green", s_g, 8);
    checkValue("dual_yellow", yel, 9);
    checkValue("dual_allred", red, 6);

    // req_s held through S green: extended to the maximum.
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      applyStimulus(1, 0, 0);
      if (light_S == G) found = 1;
    end
    checkValue("hold_s_reached", found, 1);
    cnt = found;
    for (int k = 0; k < 40 && light_S == G; k++) begin
      applyStimulus(1, 0, 0);
      if (light_S == G) cnt++;
    end
    checkValue("hold_s_green_len", cnt, 16);
    checkValue("hold_s_then_yellow", light_S, Y);
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0);
    checkOutput("hold_s_back_main", MAIN_G, 2'd0, 0);

    // Emergency preempt during S green with MT pending.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("pre_main_yellow", MAIN_Y, 2'd0, 0);
    applyStimulus(0, 1, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(0, 0, 0);
      if (light_S == G) found = 1;
    end
    checkValue("pre_s_reached", found, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0);
    checkOutput("pre_s_green4", S_G, 2'd2, 0);
    applyStimulus(0, 0, 1);
    checkOutput("pre_yellow", S_Y, 2'd2, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    checkOutput("pre_yellow_end", S_Y, 2'd2, 0);
    applyStimulus(0, 0, 1);
    checkOutput("pre_allred1", ALL_R, 2'd2, 0);
    applyStimulus(0, 0, 1);
    checkOutput("pre_allred2", ALL_R, 2'd2, 0);
    applyStimulus(0, 0, 1);
    checkOutput("pre_hold", ALL_R, 2'd2, 1);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 1);
    checkOutput("pre_hold_kept", ALL_R, 2'd2, 1);
    applyStimulus(0, 0, 0);
    checkOutput("pre_main_green", MAIN_G, 2'd0, 0);
    cnt = 1;
    for (int k = 0; k < 40 && light_M2 == G; k++) begin
      applyStimulus(0, 0, 0);
      if (light_M2 == G) cnt++;
    end
    checkValue("pre_main_len", cnt, 8);
    checkOutput("pre_main_to_yellow", MAIN_Y, 2'd0, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(0, 0, 0);
      if (light_MT == G) found = 1;
    end
    checkValue("pre_mt_served", found, 1);
    for (int k = 0; k < 40; k++) applyStimulus(0, 0, 0);

    // Reset mid-yellow with S pending: demand is discarded.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rst_mid_yellow", MAIN_Y, 2'd0, 0);
    applyReset();
    applyStimulus(0, 0, 0);
    checkOutput("rst_allred", ALL_R, 2'd0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rst_main", MAIN_G, 2'd0, 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0);
      if (light_M1 == G && light_M2 == G) cnt++;
    end
    checkValue("rst_pend_cleared", cnt, 20);

    // Randomized traffic against the model.
    em_lvl = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 59) == 0) em_lvl = !em_lvl;
      if ($urandom_range(0, 999) == 0) applyReset();
      else applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, em_lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
